// File: rtl/cellrv32_cpu_regfile_mp.sv
// Multi-port CELLRV32 register file with a post-reset clear sequencer and a per-register busy scoreboard.
// Optional macro CELLRV32_RF_BYPASS_EN: same-cycle write-to-read forwarding (write-first); default is read-first.
module cellrv32_cpu_regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     init_done_o,
    input  logic                     we_i,
    input  logic [4:0]               waddr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [NUM_RD*5-1:0]      raddr_i,
    output logic [NUM_RD*XLEN-1:0]   rdata_o,
    input  logic                     sb_set_i,
    input  logic [4:0]               sb_addr_i,
    output logic [NUM_REGS-1:0]      busy_o,
    output logic [NUM_RD-1:0]        rd_busy_o
);

    localparam int unsigned IW = $clog2(NUM_REGS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                   state, state_nxt;
    logic [IW-1:0]            clr_cnt, clr_cnt_nxt;
    logic                     done_nxt;
    logic [XLEN-1:0]          regs [NUM_REGS];
    logic                     wr_acc, sb_acc;
    logic [NUM_REGS-1:0]      busy_nxt;
    logic [NUM_RD*XLEN-1:0]   rdata_nxt;
    logic [NUM_RD-1:0]        rd_busy_nxt;

    // Addresses at or above NUM_REGS (bit 4 in RV32E) do not exist.
    function automatic logic legal(input logic [4:0] a);
        return 32'(a) < 32'(NUM_REGS);
    endfunction

    assign wr_acc = (state == READY) && we_i && legal(waddr_i) && (waddr_i != 5'd0);
    assign sb_acc = (state == READY) && sb_set_i && legal(sb_addr_i) && (sb_addr_i != 5'd0);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            init_done_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            init_done_o <= done_nxt;
        end
    end

    // Clear sequencer: one entry per cycle, then park in READY
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        done_nxt    = init_done_o;
        case (state)
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + IW'(1);
                if (clr_cnt == IW'(NUM_REGS - 1)) begin
                    state_nxt   = READY;
                    clr_cnt_nxt = '0;
                    done_nxt    = 1'b1;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Storage has no reset so it can map onto RAM; CLEAR zeroes it instead.
    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            regs[clr_cnt] <= '0;
        end else if (wr_acc) begin
            regs[IW'(waddr_i)] <= wdata_i;
        end
    end

    // Scoreboard: retire on write, set on issue; set applied last so it wins
    always_comb begin
        busy_nxt = busy_o;
        if (wr_acc) begin
            busy_nxt[IW'(waddr_i)] = 1'b0;
        end
        if (sb_acc) begin
            busy_nxt[IW'(sb_addr_i)] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o <= '0;
        end else begin
            busy_o <= busy_nxt;
        end
    end

    // Read ports
    always_comb begin
        rdata_nxt   = '0;
        rd_busy_nxt = '0;
        if (state == READY) begin
            for (int k = 0; k < int'(NUM_RD); k++) begin
                if (legal(raddr_i[k*5 +: 5])) begin
                    rdata_nxt[k*XLEN +: XLEN] = regs[IW'(raddr_i[k*5 +: 5])];
                    rd_busy_nxt[k]            = busy_o[IW'(raddr_i[k*5 +: 5])];
                end
`ifdef CELLRV32_RF_BYPASS_EN
                if (wr_acc && (raddr_i[k*5 +: 5] == waddr_i)) begin
                    rdata_nxt[k*XLEN +: XLEN] = wdata_i;
                    rd_busy_nxt[k]            = sb_acc && (sb_addr_i == waddr_i);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o   <= '0;
            rd_busy_o <= '0;
        end else begin
            rdata_o   <= rdata_nxt;
            rd_busy_o <= rd_busy_nxt;
        end
    end

endmodule

// File: tb/tb_cellrv32_cpu_regfile_mp.sv
// Self-checking bench for cellrv32_cpu_regfile_mp: default 32x2 instance plus an RV32E 16x1 instance.
// Expectations follow CELLRV32_RF_BYPASS_EN when it is defined for the build.
module tb_cellrv32_cpu_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default configuration instance
    logic        we, sb_set, init_done;
    logic [4:0]  waddr, sb_addr;
    logic [31:0] wdata, busy;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rd_busy;

    cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) dut (
        .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr),
        .busy_o(busy), .rd_busy_o(rd_busy)
    );

    // RV32E instance
    logic        b_we, b_sb_set, b_init_done;
    logic [4:0]  b_waddr, b_sb_addr, b_raddr;
    logic [31:0] b_wdata, b_rdata;
    logic [15:0] b_busy;
    logic [0:0]  b_rd_busy;

    cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(16), .NUM_RD(1)) dut_e (
        .clk_i(clk), .rst_i(rst), .init_done_o(b_init_done),
        .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
        .raddr_i(b_raddr), .rdata_o(b_rdata),
        .sb_set_i(b_sb_set), .sb_addr_i(b_sb_addr),
        .busy_o(b_busy), .rd_busy_o(b_rd_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model of the default instance
    logic [31:0] mregs [32];
    logic [31:0] mbusy;

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  rbusy;
        logic [31:0] busy;
    } exp_t;
    exp_t sb_q[$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mbusy = '0;
    endtask

    // One READY cycle on the default instance: drive, predict, clock, compare
    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic s, input logic [4:0] sa);
        exp_t e;
        logic wacc, sacc;
        logic [4:0] ra;
        we = w; waddr = wa; wdata = wd; raddr = {r1, r0}; sb_set = s; sb_addr = sa;
        wacc = w && (wa != 5'd0);
        sacc = s && (sa != 5'd0);
        for (int k = 0; k < 2; k++) begin
            ra = (k == 1) ? r1 : r0;
            e.rdata[k*32 +: 32] = mregs[ra];
            e.rbusy[k]          = mbusy[ra];
`ifdef CELLRV32_RF_BYPASS_EN
            if (wacc && ra == wa) begin
                e.rdata[k*32 +: 32] = wd;
                e.rbusy[k]          = sacc && (sa == ra);
            end
`endif
        end
        if (wacc) begin
            mregs[wa] = wd;
            mbusy[wa] = 1'b0;
        end
        if (sacc) mbusy[sa] = 1'b1;
        e.busy = mbusy;
        sb_q.push_back(e);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("rd_busy", {62'd0, rd_busy}, {62'd0, e.rbusy});
        check("busy", {32'd0, busy}, {32'd0, e.busy});
        we = 1'b0; sb_set = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0, r1;
        logic        sb;
        logic [4:0]  sa;
        logic [31:0] exp_rd0;
        logic [31:0] exp_busy;
    } vec_t;
    vec_t vt [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit done;
        logic [31:0] exp7;

        vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        vt[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        vt[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};
        vt[4] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 5'd9, 32'hDEADBEEF, 32'h200};
        vt[5] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd5, 1'b0, 5'd0, 32'h0,        32'h200};
        vt[6] = '{1'b1, 5'd9, 32'h99,       5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0};
        vt[7] = '{1'b1, 5'd9, 32'hA5,       5'd1, 5'd0, 1'b1, 5'd9, 32'h0,        32'h200};
        vt[8] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 5'd0, 32'hA5,       32'h200};
        vt[9] = '{1'b1, 5'd9, 32'h5A,       5'd3, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0};

        rst = 1'b1;
        we = 0; waddr = 0; wdata = 0; raddr = 0; sb_set = 0; sb_addr = 0;
        b_we = 0; b_waddr = 0; b_wdata = 0; b_raddr = 0; b_sb_set = 0; b_sb_addr = 0;
        model_reset();
        repeat (2) cyc();
        check("reset init_done", {63'd0, init_done}, 64'd0);
        check("reset rdata", rdata, 64'd0);
        check("reset busy", {32'd0, busy}, 64'd0);

        // Clear sequence with writes and sets pounding the inputs (must be ignored)
        we = 1'b1; waddr = 5'd2; wdata = 32'hFFFF_FFFF; raddr = {5'd2, 5'd2};
        sb_set = 1'b1; sb_addr = 5'd6;
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            cyc();
            check($sformatf("init_done cyc%0d", i), {63'd0, init_done}, {63'd0, (i == 32)});
            if (i == 15 || i == 16)
                check($sformatf("e init_done cyc%0d", i), {63'd0, b_init_done}, {63'd0, (i == 16)});
            if (i == 20) check("rdata held in clear", rdata, 64'd0);
            if (i == 31) begin
                we = 1'b0; sb_set = 1'b0;
            end
        end

        // Every address reads zero after clear
        for (int i = 0; i < 16; i++) step(0, 0, 0, 5'(2*i), 5'(2*i+1), 0, 0);

        // Table-driven write/read/scoreboard vectors
        for (int i = 0; i < 10; i++) begin
            step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].r0, vt[i].r1, vt[i].sb, vt[i].sa);
            check($sformatf("vec%0d rd0", i), {32'd0, rdata[31:0]}, {32'd0, vt[i].exp_rd0});
            check($sformatf("vec%0d busy", i), {32'd0, busy}, {32'd0, vt[i].exp_busy});
        end

        // Same-cycle write/read of x7
        step(1, 5'd7, 32'h11, 5'd0, 5'd0, 0, 0);
        step(1, 5'd7, 32'h22, 5'd7, 5'd7, 0, 0);
`ifdef CELLRV32_RF_BYPASS_EN
        exp7 = 32'h22;
`else
        exp7 = 32'h11;
`endif
        check("x7 same-cycle", {32'd0, rdata[31:0]}, {32'd0, exp7});
        step(0, 0, 0, 5'd7, 5'd7, 0, 0);
        check("x7 next read", {32'd0, rdata[63:32]}, 64'h22);

        // Same-cycle set + write with a same-address read
        step(1, 5'd10, 32'hC0DE, 5'd10, 5'd0, 1, 5'd10);
        step(0, 0, 0, 5'd10, 5'd0, 0, 0);

        // RV32E: illegal address 17 must not alias x1
        b_we = 1'b1; b_waddr = 5'd1; b_wdata = 32'h77;
        cyc();
        b_waddr = 5'd17; b_wdata = 32'hAA;
        cyc();
        b_we = 1'b0; b_raddr = 5'd1;
        cyc();
        check("e x1 after addr17 write", {32'd0, b_rdata}, 64'h77);
        b_raddr = 5'd17; b_sb_set = 1'b1; b_sb_addr = 5'd17;
        cyc();
        check("e read addr17", {32'd0, b_rdata}, 64'd0);
        check("e rd_busy addr17", {63'd0, b_rd_busy}, 64'd0);
        b_sb_addr = 5'd2;
        cyc();
        check("e busy after set17", {48'd0, b_busy}, 64'h4);
        b_sb_set = 1'b0; b_raddr = 5'd2;
        cyc();
        check("e rd_busy x2", {63'd0, b_rd_busy}, 64'd1);

        // Reset mid-operation with x3 pending
        step(1, 5'd3, 32'h55, 5'd0, 5'd0, 0, 0);
        step(0, 0, 0, 5'd3, 5'd0, 1, 5'd3);
        check("x3 busy before reset", {63'd0, busy[3]}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("busy async reset", {32'd0, busy}, 64'd0);
        check("e busy async reset", {48'd0, b_busy}, 64'd0);
        check("init_done async reset", {63'd0, init_done}, 64'd0);
        cyc();
        rst = 1'b0;
        model_reset();
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cyc();
            if (init_done) done = 1'b1;
        end
        check("reclear completes", {63'd0, done}, 64'd1);
        step(0, 0, 0, 5'd3, 5'd9, 0, 0);
        check("x3 after reclear", {32'd0, rdata[31:0]}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cellrv32_cpu_regfile_mp.md
# cellrv32_cpu_regfile_mp

Parametrised multi-port general-purpose register file for the CELLRV32 CPU, replacing the fixed 2/4-read-port RF. Depth (16 or 32 entries) and read-port count (1..4) are generic. A hardware clear sequencer zeroes every entry after reset, and a per-register busy scoreboard tracks long-latency writes. The block sits between the control unit (addresses, scoreboard commands) and the write-back mux; the write-back mux stays in the CPU.

## Interface
Parameters:
- XLEN, 32: data width.
- NUM_REGS, 32: register count; legal values 16 (RV32E) or 32.
- NUM_RD, 2: number of read ports; legal values 1..4.

Ports:
- clk_i  in  1  global clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- init_done_o  out  1  high once the clear sequence has finished.
- we_i  in  1  write enable.
- waddr_i  in  5  write address.
- wdata_i  in  XLEN  write data.
- raddr_i  in  NUM_RD*5  read addresses; port k uses bits [5k+4:5k].
- rdata_o  out  NUM_RD*XLEN  registered read data; port k uses bits [XLEN*k+XLEN-1:XLEN*k].
- sb_set_i  in  1  mark register sb_addr_i as pending.
- sb_addr_i  in  5  scoreboard set address.
- busy_o  out  NUM_REGS  busy bit per register.
- rd_busy_o  out  NUM_RD  registered busy flag of each read port's address.

## Operation
- FSM states:
  - CLEAR: entered on reset. A counter steps 0..NUM_REGS-1 and writes 0 to one entry per cycle. After entry NUM_REGS-1, the FSM moves to READY.
  - READY: normal operation; the FSM stays here until reset.
- While in CLEAR:
  - we_i and sb_set_i are ignored.
  - rdata_o and rd_busy_o are held at 0.
- Writes: in READY, with we_i=1 and a legal address, wdata_i is stored on the clock edge.
  - Address 0 is never written; x0 reads 0 from the clear onward.
- Legal address: waddr_i < NUM_REGS. With NUM_REGS=16, any address with bit 4 set is illegal:
  - A write to it is dropped.
  - A read of it returns 0 and rd_busy_o=0.
- Scoreboard:
  - sb_set_i=1 with a legal, non-zero sb_addr_i sets busy_o[sb_addr_i].
  - An accepted write clears busy_o[waddr_i].
  - If a set and a clear hit the same address in the same cycle, the set wins: a new op is issued while the old one retires.
  - busy_o[0] is always 0.
- Reads: every port samples its address every cycle. rdata_o and rd_busy_o reflect the state captured at that clock edge.

## Timing
- Reset values: init_done_o=0, rdata_o=0, rd_busy_o=0, busy_o=0, clear counter=0, FSM=CLEAR.
- Clear duration: init_done_o rises on the NUM_REGS-th rising edge after rst_i deasserts, i.e. 32 cycles for the default configuration.
- Read latency: 1 cycle. An address presented in cycle n produces data in cycle n+1.
- Write latency: 1 cycle. The write is visible to reads sampled in cycle n+1; same-cycle behaviour is set by the configuration macro below.
- Reset mid-operation (any state): contents are cleared again via CLEAR, and busy bits reset immediately.

## Configuration
- Macro: CELLRV32_RF_BYPASS_EN.
- Defined: a read port whose address equals an accepted write's waddr_i in the same cycle returns wdata_i (write-first). rd_busy_o for that port is then 0, unless a same-address sb_set_i sets it to 1.
- Not defined: such a read returns the old contents and the old busy state (read-first), which allows block-RAM mapping.

## Test plan
- Clear sequence: release reset. Require init_done_o=0 for 31 cycles and 1 on cycle 32, and rdata_o=0 for all 32 addresses afterwards.
- Write/read: write 0xDEADBEEF to x5, then read x5 on all ports in the next cycle; require 0xDEADBEEF one cycle later. Write 0x1234 to x0; a read of x0 must return 0.
- Same-cycle write/read of x7 (old value 0x11, new value 0x22):
  - With CELLRV32_RF_BYPASS_EN defined, require 0x22.
  - Without it, require 0x11 in that cycle and 0x22 on the next read.
- Scoreboard:
  - sb_set_i on x9 gives busy_o[9]=1; a write to x9 clears it.
  - A set and a write to x9 in the same cycle leave busy_o[9]=1.
  - sb_set_i on x0 leaves busy_o=0.
- NUM_REGS=16: a write of 0xAA to address 17 must leave x1 unchanged. A read of address 17 must return 0.
- Reset asserted mid-operation with x3=0x55 and busy_o[3]=1: busy_o=0 immediately, FSM returns to CLEAR, and x3 reads 0 after init_done_o rises.
